// File: rtl/bmem_arbiter_pkg.sv
// Shared types for the two-core burst memory arbiter.
// State encoding, line geometry defaults and requester ids.
package bmem_arbiter_pkg;

  localparam int LINE_W_DEF = 256;
  localparam int BEATS_DEF  = LINE_W_DEF / 64;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_BURST,
    DONE
  } arb_state_e;

  typedef enum logic {
    PORT_C0 = 1'b0,
    PORT_C1 = 1'b1
  } port_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester not
// served last wins; a lone requester always wins.
module rr_arbiter2
  import bmem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_id_e   last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b11:   gnt_o = (last_i == PORT_C1) ? 2'b01 : 2'b10;
      default: gnt_o = req_i;
    endcase
  end

endmodule

// File: rtl/bmem_arbiter.sv
// Arbitrates two cache-line requesters onto a 64-bit burst memory.
// Define BMEM_ARB_LOCK_EN to block c0 on the c1 AMO reservation line.
module bmem_arbiter
  import bmem_arbiter_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int BEATS  = BEATS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       c0_addr,
  input  logic              c0_read,
  input  logic              c0_write,
  input  logic [LINE_W-1:0] c0_wdata,
  output logic [LINE_W-1:0] c0_rdata,
  output logic              c0_resp,
  input  logic [31:0]       c1_addr,
  input  logic              c1_read,
  input  logic              c1_write,
  input  logic [LINE_W-1:0] c1_wdata,
  output logic [LINE_W-1:0] c1_rdata,
  output logic              c1_resp,
  input  logic              lock,
  input  logic [31:0]       lock_addr,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [63:0]       bmem_wdata,
  input  logic              bmem_ready,
  input  logic [31:0]       bmem_raddr,
  input  logic [63:0]       bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam int KW = (BEATS > 1) ? $clog2(BEATS) : 1;

  arb_state_e        state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  port_id_e          port_q, last_q;
  logic [31:0]       addr_q;
  logic [LINE_W-1:0] wdata_q, rbuf_q;
  logic [LINE_W-1:0] rdata0_q, rdata1_q;
  logic [LINE_W-1:0] line_fill;

  logic              c0_locked;
  logic [1:0]        req, gnt;
  logic              last_k, beat_hit;
  logic              sel_write;
  logic [31:0]       sel_addr;
  logic [LINE_W-1:0] sel_wdata;

`ifdef BMEM_ARB_LOCK_EN
  logic [4:0] unused_lock;
  assign unused_lock = lock_addr[4:0];
  assign c0_locked   = lock && (c0_addr[31:5] == lock_addr[31:5]);
`else
  logic [32:0] unused_lock;
  assign unused_lock = {lock, lock_addr};
  assign c0_locked   = 1'b0;
`endif

  assign req[0] = (c0_read | c0_write) & ~c0_locked;
  assign req[1] = c1_read | c1_write;

  rr_arbiter2 u_rr (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  // read+write together on one port counts as a write
  assign sel_write = gnt[1] ? c1_write : c0_write;
  assign sel_addr  = gnt[1] ? c1_addr  : c0_addr;
  assign sel_wdata = gnt[1] ? c1_wdata : c0_wdata;

  assign last_k   = (k_q == KW'(BEATS - 1));
  assign beat_hit = (state_q == RD_WAIT) && bmem_rvalid &&
                    (bmem_raddr == addr_q);

  always_comb begin
    line_fill = rbuf_q;
    line_fill[{k_q, 6'd0} +: 64] = bmem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (|gnt) state_d = sel_write ? WR_BURST : RD_ISSUE;
      end
      RD_ISSUE: begin
        if (bmem_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (beat_hit) begin
          k_d = k_q + 1'b1;
          if (last_k) state_d = DONE;
        end
      end
      WR_BURST: begin
        if (bmem_ready) begin
          k_d = k_q + 1'b1;
          if (last_k) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        k_d     = '0;
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      port_q   <= PORT_C0;
      last_q   <= PORT_C1;
      addr_q   <= '0;
      wdata_q  <= '0;
      rbuf_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (state_q == IDLE && (|gnt)) begin
        port_q  <= gnt[1] ? PORT_C1 : PORT_C0;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      // port rdata only changes when the full line is in
      if (beat_hit) begin
        rbuf_q <= line_fill;
        if (last_k) begin
          if (port_q == PORT_C1) rdata1_q <= line_fill;
          else                   rdata0_q <= line_fill;
        end
      end
      if (state_q == DONE) last_q <= port_q;
    end
  end

  always_comb begin
    bmem_read  = (state_q == RD_ISSUE);
    bmem_write = (state_q == WR_BURST);
    bmem_addr  = '0;
    bmem_wdata = '0;
    c0_resp    = 1'b0;
    c1_resp    = 1'b0;
    if (bmem_read || bmem_write) bmem_addr = addr_q;
    if (bmem_write) bmem_wdata = wdata_q[{k_q, 6'd0} +: 64];
    if (state_q == DONE) begin
      c0_resp = (port_q == PORT_C0);
      c1_resp = (port_q == PORT_C1);
    end
  end

  assign c0_rdata = rdata0_q;
  assign c1_rdata = rdata1_q;

endmodule

// File: tb/tb_bmem_arbiter.sv
// Scoreboard bench for bmem_arbiter: directed bursts, queued
// expectations, negedge monitor checks resps and write beats.
module tb_bmem_arbiter;

  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   c0_addr, c1_addr, lock_addr;
  logic          c0_read, c0_write, c1_read, c1_write, lock;
  logic [LW-1:0] c0_wdata, c1_wdata, c0_rdata, c1_rdata;
  logic          c0_resp, c1_resp;
  logic [31:0]   bmem_addr, bmem_raddr;
  logic          bmem_read, bmem_write, bmem_ready, bmem_rvalid;
  logic [63:0]   bmem_wdata, bmem_rdata;

  always #5 clk = ~clk;

  bmem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .c0_addr     (c0_addr),
    .c0_read     (c0_read),
    .c0_write    (c0_write),
    .c0_wdata    (c0_wdata),
    .c0_rdata    (c0_rdata),
    .c0_resp     (c0_resp),
    .c1_addr     (c1_addr),
    .c1_read     (c1_read),
    .c1_write    (c1_write),
    .c1_wdata    (c1_wdata),
    .c1_rdata    (c1_rdata),
    .c1_resp     (c1_resp),
    .lock        (lock),
    .lock_addr   (lock_addr),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  typedef struct {
    int            port;
    logic [LW-1:0] data;
  } exp_t;

  exp_t        rq[$];
  logic [95:0] wq[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc_n = 0;

  always @(posedge clk) cyc_n++;

  task automatic chk(input string nm, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got event, want none", nm);
  endtask

  // monitor
  always @(negedge clk) begin
    exp_t        e;
    logic [95:0] w;
    if (bmem_read || bmem_write)
      chk("rw_excl", LW'(bmem_read & bmem_write), '0);
    if (bmem_write && bmem_ready) begin
      if (wq.size() == 0) bad("wr_extra_beat");
      else begin
        w = wq.pop_front();
        chk("wr_beat", LW'({bmem_addr, bmem_wdata}), LW'(w));
      end
    end
    if (c0_resp || c1_resp) begin
      if (c0_resp && c1_resp) bad("resp_both");
      else if (rq.size() == 0) bad("resp_extra");
      else begin
        e = rq.pop_front();
        chk("resp_port", LW'(c1_resp), LW'(e.port));
        chk("resp_rdata", c1_resp ? c1_rdata : c0_rdata, e.data);
      end
    end
  end

  function automatic logic [LW-1:0] line4(input logic [63:0] a,
    input logic [63:0] b, input logic [63:0] c, input logic [63:0] d);
    return {d, c, b, a};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic serve_read(input logic [31:0] addr,
    input logic [LW-1:0] line, input bit spur, input int nb);
    int t;
    t = 0;
    bmem_ready = 1'b1;
    while (!bmem_read && t < 40) begin
      cyc();
      t++;
    end
    chk("rd_issue", LW'(bmem_read), LW'(1'b1));
    chk("rd_addr", LW'(bmem_addr), LW'(addr));
    cyc();
    for (int i = 0; i < nb; i++) begin
      if (spur && i == 2) begin
        bmem_rvalid = 1'b1;
        bmem_raddr  = 32'h3000;
        bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        cyc();
      end
      bmem_rvalid = 1'b1;
      bmem_raddr  = addr;
      bmem_rdata  = line[i*64 +: 64];
      cyc();
    end
    bmem_rvalid = 1'b0;
  endtask

  task automatic wait_resp(input int port);
    int t;
    t = 0;
    while (!(port == 1 ? c1_resp : c0_resp) && t < 20) begin
      cyc();
      t++;
    end
    if (t >= 20) begin
      n_chk++;
      n_fail++;
      $display("FAIL resp_timeout: port %0d got no resp, want resp", port);
    end
    if (port == 1) begin
      c1_read  = 1'b0;
      c1_write = 1'b0;
    end else begin
      c0_read  = 1'b0;
      c0_write = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] la, lb, lc, ld, le, lf, lg, lw, lh, lj, mdl1;
    int            t0, t;
    bit            seen;
    bit            pat[6];

    c0_addr = '0; c1_addr = '0; lock_addr = '0;
    c0_read = 0; c0_write = 0; c1_read = 0; c1_write = 0; lock = 0;
    c0_wdata = '0; c1_wdata = '0;
    bmem_ready = 0; bmem_rvalid = 0; bmem_raddr = '0; bmem_rdata = '0;

    la = line4(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
    lb = line4(64'h5555_0000_0000_0001, 64'h5555_0000_0000_0002,
               64'h5555_0000_0000_0003, 64'h5555_0000_0000_0004);
    lc = line4(64'hC0, 64'hC1, 64'hC2, 64'hC3);
    ld = line4(64'hD0, 64'hD1, 64'hD2, 64'hD3);
    le = line4(64'hE0E0, 64'hE1E1, 64'hE2E2, 64'hE3E3);
    lf = line4(64'hF0, 64'hF1, 64'hF2, 64'hF3);
    lg = line4(64'h60, 64'h61, 64'h62, 64'h63);
    lw = line4(64'hA000_0000_0000_00A0, 64'hA000_0000_0000_00A1,
               64'hA000_0000_0000_00A2, 64'hA000_0000_0000_00A3);
    lh = line4(64'h70, 64'h71, 64'h72, 64'h73);
    lj = line4(64'h90, 64'h91, 64'h92, 64'h93);

    repeat (3) cyc();
    chk("rst_bmem_read", LW'(bmem_read), '0);
    chk("rst_bmem_write", LW'(bmem_write), '0);
    chk("rst_bmem_addr", LW'(bmem_addr), '0);
    chk("rst_bmem_wdata", LW'(bmem_wdata), '0);
    chk("rst_resp", LW'({c0_resp, c1_resp}), '0);
    chk("rst_c0_rdata", c0_rdata, '0);
    chk("rst_c1_rdata", c1_rdata, '0);
    rst = 1'b1;
    cyc();

    // both from reset: c0 wins the first tie
    rq.push_back('{0, la});
    rq.push_back('{1, lb});
    c0_addr = 32'h1000; c1_addr = 32'h1040;
    c0_read = 1; c1_read = 1;
    t0 = cyc_n;
    serve_read(32'h1000, la, 0, 4);
    wait_resp(0);
    chk("rd_latency", LW'(cyc_n - t0), LW'(6));
    serve_read(32'h1040, lb, 0, 4);
    wait_resp(1);

    // tie again, last served c1 -> c0 first
    rq.push_back('{0, lc});
    rq.push_back('{1, ld});
    c0_addr = 32'h1080; c1_addr = 32'h10A0;
    c0_read = 1; c1_read = 1;
    serve_read(32'h1080, lc, 0, 4);
    wait_resp(0);
    serve_read(32'h10A0, ld, 0, 4);
    wait_resp(1);

    // lone c0 with a stray beat for another address mid-burst
    rq.push_back('{0, le});
    c0_addr = 32'h10C0;
    c0_read = 1;
    serve_read(32'h10C0, le, 1, 4);
    wait_resp(0);

    // tie, last served c0 -> c1 first
    rq.push_back('{1, lg});
    rq.push_back('{0, lf});
    c0_addr = 32'h1100; c1_addr = 32'h1120;
    c0_read = 1; c1_read = 1;
    serve_read(32'h1120, lg, 0, 4);
    wait_resp(1);
    serve_read(32'h1100, lf, 0, 4);
    wait_resp(0);
    mdl1 = lg;

    // c1 read+write together is a write; ready stalls
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bmem_ready = 0;
    for (int i = 0; i < 4; i++) wq.push_back({32'h2000, lw[i*64 +: 64]});
    rq.push_back('{1, mdl1});
    c1_addr = 32'h2000; c1_wdata = lw;
    c1_read = 1; c1_write = 1;
    t = 0;
    while (!bmem_write && t < 40) begin
      cyc();
      t++;
    end
    chk("wr_issue", LW'(bmem_write), LW'(1'b1));
    for (int j = 0; j < 6; j++) begin
      bmem_ready = pat[j];
      cyc();
    end
    bmem_ready = 0;
    wait_resp(1);
    c1_wdata = '0;
    cyc();
    chk("wr_beats_left", LW'(wq.size()), '0);

`ifdef BMEM_ARB_LOCK_EN
    lock = 1; lock_addr = 32'h1004;
    c0_addr = 32'h1000; c0_read = 1;
    bmem_ready = 1;
    seen = 0;
    repeat (10) begin
      cyc();
      if (bmem_read) seen = 1;
    end
    chk("lock_blocks_c0", LW'(seen), '0);
    rq.push_back('{1, lh});
    c1_addr = 32'h1000; c1_read = 1;
    serve_read(32'h1000, lh, 0, 4);
    wait_resp(1);
    rq.push_back('{0, lj});
    lock = 0;
    serve_read(32'h1000, lj, 0, 4);
    wait_resp(0);
`else
    seen = 0;
    lock = 1; lock_addr = 32'h1004;
    rq.push_back('{0, lj});
    c0_addr = 32'h1000; c0_read = 1;
    serve_read(32'h1000, lj, 0, 4);
    wait_resp(0);
    lock = 0;
    chk("lock_ignored", LW'(seen), '0);
`endif
    cyc();

    // reset after three beats of a read
    c0_addr = 32'h1000; c0_read = 1;
    serve_read(32'h1000, lh, 0, 3);
    rst = 1'b0;
    #1;
    chk("mid_rst_read", LW'(bmem_read), '0);
    chk("mid_rst_addr", LW'(bmem_addr), '0);
    chk("mid_rst_resp", LW'({c0_resp, c1_resp}), '0);
    chk("mid_rst_c0_rdata", c0_rdata, '0);
    chk("mid_rst_c1_rdata", c1_rdata, '0);
    c0_read = 0;
    cyc();
    cyc();
    rst = 1'b1;
    bmem_rvalid = 1; bmem_raddr = 32'h1000; bmem_rdata = lh[192 +: 64];
    cyc();
    bmem_rvalid = 0;
    repeat (3) cyc();
    chk("late_beat_ignored", c0_rdata, '0);

    rq.push_back('{0, la});
    c0_addr = 32'h1100; c0_read = 1;
    serve_read(32'h1100, la, 0, 4);
    wait_resp(0);
    repeat (3) cyc();

    chk("resp_left", LW'(rq.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
